// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: byte-serial 8N1 UART transmitter.
//
// Accepts bytes over a valid/ready handshake, queues them and shifts each one
// out on `tx` as a frame: one start bit (0), 8 data bits LSB first, and one
// stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles. Consecutive frames
// are sent with no idle gap while bytes are waiting.
//
// Configuration macro: UART_TX_FIFO_EN
//   defined   -> FIFO_DEPTH-entry transmit FIFO (power of two, >= 2)
//   undefined -> one holding register plus a valid flag; FIFO_DEPTH ignored
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 2); 10417 = 9600 Bd @ 100 MHz
//   FIFO_DEPTH    transmit FIFO entries (only with UART_TX_FIFO_EN)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   data        in   byte to send, sampled when data_valid && data_ready
//   data_valid  in   producer holds a byte on `data`
//   data_ready  out  block can accept a byte this cycle (combinational)
//   tx          out  serial line, idle high, registered
//   busy        out  frame on the line or any byte buffered (combinational)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Elaboration-time parameter sanity checks.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Queue-side handshake shared by both buffer flavours.
    logic       push;
    logic       pop;
    logic       q_empty;
    logic [7:0] q_head;

    assign push = data_valid && data_ready;

`ifdef UART_TX_FIFO_EN
    // ---------------------------------------------------------------------
    // Transmit FIFO; pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------------
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        q_full;

    assign q_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop on a full FIFO only frees the slot for the following cycle.
    assign data_ready = !q_full && rst_n;

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data;
        end
    end
`else
    // ---------------------------------------------------------------------
    // Single holding register: at most one byte waits behind the frame.
    // ---------------------------------------------------------------------
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign q_empty    = !hold_valid_q;
    assign q_head     = hold_q;
    assign data_ready = !hold_valid_q && rst_n;

    // Push only happens when empty and pop only when full, so they never collide.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            hold_d       = data;
            hold_valid_d = 1'b1;
        end
    end

    // Holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Frame sequencer.
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, baud counting and pop requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    sh_d    = q_head;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when a byte waits.
                    if (!q_empty) begin
                        pop     = 1'b1;
                        sh_d    = q_head;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level follows the current state one cycle later, giving the
    // accept -> pop -> start-bit latency of two edges.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_q[bit_q];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !q_empty;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int unsigned C     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * C;
`ifdef UART_TX_FIFO_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // ---------------- line monitor: decodes 8N1 frames off tx ----------------
    bit          in_frame = 1'b0;
    int unsigned fall_e;
    int unsigned pos;
    logic [9:0]  frame_bits;
    logic        prev_tx = 1'b1;
    logic        prev_busy = 1'b0;
    int          glitches = 0;
    logic [7:0]  rx_q[$];
    int unsigned fall_q[$];
    logic        stop_q[$];
    logic        start_q[$];
    int unsigned busy_fall_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (in_frame) begin
            pos = edge_cnt - fall_e;
            if ((pos % C) != 0 && tx !== prev_tx) glitches++;
            if ((pos % C) == C / 2) begin
                frame_bits[pos / C] = tx;
                if (pos / C == 9) begin
                    rx_q.push_back(frame_bits[8:1]);
                    start_q.push_back(frame_bits[0]);
                    stop_q.push_back(frame_bits[9]);
                    fall_q.push_back(fall_e);
                    in_frame = 1'b0;
                end
            end
        end else if (prev_tx === 1'b1 && tx === 1'b0) begin
            in_frame = 1'b1;
            fall_e   = edge_cnt;
        end
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_q.push_back(edge_cnt);
        prev_tx   = tx;
        prev_busy = busy;
    end

    // ---------------- stimulus helpers and reference model ----------------
    logic [7:0]  tx_bytes[$];
    int unsigned acc_e[$];
    int unsigned exp_acc[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete(); fall_q.delete(); stop_q.delete(); start_q.delete();
        busy_fall_q.delete(); glitches = 0;
    endtask

    // Hold data_valid and walk through tx_bytes, recording each accepting edge.
    task automatic send_all(input int unsigned bound);
        int unsigned w;
        bit got;
        acc_e.delete();
        foreach (tx_bytes[i]) begin
            w = 0; got = 1'b0;
            data = tx_bytes[i]; data_valid = 1'b1;
            while (!got && w < bound) begin
                @(negedge clk);
                if (data_ready === 1'b1) begin
                    acc_e.push_back(edge_cnt + 1);
                    got = 1'b1;
                end
                @(posedge clk); #1;
                w++;
            end
            chk_cnt++;
            if (!got) $display("FAIL accept_timeout: byte %0d not accepted within %0d cycles", i, bound);
            else pass_cnt++;
        end
        data_valid = 1'b0;
        data = 8'($urandom);
    endtask

    // Wait for the block to drain, scrambling the idle data bus meanwhile.
    task automatic wait_idle(input int unsigned bound, output bit ok);
        ok = 1'b0;
        for (int unsigned w = 0; w < bound; w++) begin
            data = 8'($urandom);
            tick(1);
            if (busy === 1'b0 && !in_frame) begin ok = 1'b1; break; end
        end
        tick(2);
    endtask

    // Capacity model: queue holds CAP bytes, line pops one byte on the edge after
    // the first accept and then every FRAME cycles; ready depends on occupancy
    // before the edge. Producer always has a byte available.
    function automatic void model_accepts(input int unsigned n, input int unsigned first);
        int unsigned occ, e, next_pop, pushed;
        bit can_push, do_pop;
        exp_acc.delete();
        occ = 0; e = first; next_pop = first + 1; pushed = 0;
        while (pushed < n) begin
            can_push = (occ < CAP);
            do_pop   = (e == next_pop) && (occ > 0);
            if (do_pop) next_pop += FRAME;
            if (can_push) begin exp_acc.push_back(e); pushed++; end
            occ = occ + (can_push ? 1 : 0) - (do_pop ? 1 : 0);
            e++;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; data_valid = 1'b1; data = 8'hA5;
        tick(3);
        chk_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (data_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", data_ready); else pass_cnt++;
        data_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (data_ready !== 1'b1) $display("FAIL reset_ready_release: got %b want 1", data_ready); else pass_cnt++;
        tick(4);
        chk_cnt++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL reset_idle: busy %b tx %b want 0/1", busy, tx); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [7:0] b;
        bit ok;
        int unsigned first;
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'hAB : 8'($urandom);
            clear_mon();
            tx_bytes = '{b};
            first = edge_cnt + 1;
            send_all(4);
            wait_idle(FRAME + 20, ok);
            chk_cnt++; if (!ok) $display("FAIL single_drain: busy still high"); else pass_cnt++;
            chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== b)
                $display("FAIL single_byte: got %0d frames, first %h want 1 frame %h", rx_q.size(), rx_q[0], b);
            else pass_cnt++;
            chk_cnt++; if (acc_e[0] != first) $display("FAIL single_accept: edge %0d want %0d", acc_e[0], first); else pass_cnt++;
            chk_cnt++; if (fall_q[0] != first + 2) $display("FAIL single_latency: start at %0d want %0d", fall_q[0], first + 2); else pass_cnt++;
            chk_cnt++; if (start_q[0] !== 1'b0 || stop_q[0] !== 1'b1)
                $display("FAIL single_framing: start %b stop %b want 0/1", start_q[0], stop_q[0]);
            else pass_cnt++;
            // busy drops as the sequencer leaves STOP, one cycle before the stop bit ends on the line.
            chk_cnt++; if (busy_fall_q.size() != 1 || busy_fall_q[0] != first + 1 + FRAME)
                $display("FAIL single_busy: fell at %0d (%0d falls) want %0d", busy_fall_q[0], busy_fall_q.size(), first + 1 + FRAME);
            else pass_cnt++;
            chk_cnt++; if (glitches != 0) $display("FAIL single_glitch: %0d mid-bit edges want 0", glitches); else pass_cnt++;
        end
    endtask

    task automatic test_burst();
        bit ok;
        int unsigned first;
        clear_mon();
        tx_bytes = '{8'hAB, 8'hFF, 8'h00, 8'h12};
        first = edge_cnt + 1;
        model_accepts(4, first);
        send_all(FRAME + 10);
        wait_idle(5 * FRAME, ok);
        chk_cnt++; if (!ok) $display("FAIL burst_drain: busy still high"); else pass_cnt++;
        foreach (exp_acc[i]) begin
            chk_cnt++; if (acc_e[i] != exp_acc[i]) $display("FAIL burst_accept[%0d]: edge %0d want %0d", i, acc_e[i], exp_acc[i]); else pass_cnt++;
        end
        chk_cnt++; if (rx_q.size() != 4) $display("FAIL burst_count: got %0d frames want 4", rx_q.size()); else pass_cnt++;
        foreach (tx_bytes[i]) begin
            chk_cnt++; if (rx_q[i] !== tx_bytes[i] || stop_q[i] !== 1'b1 || fall_q[i] != first + 2 + i * FRAME)
                $display("FAIL burst_frame[%0d]: byte %h stop %b start %0d want %h 1 %0d",
                         i, rx_q[i], stop_q[i], fall_q[i], tx_bytes[i], first + 2 + i * FRAME);
            else pass_cnt++;
        end
        chk_cnt++; if (busy_fall_q.size() != 1 || busy_fall_q[0] != first + 1 + 4 * FRAME)
            $display("FAIL burst_busy: fell at %0d (%0d falls) want %0d", busy_fall_q[0], busy_fall_q.size(), first + 1 + 4 * FRAME);
        else pass_cnt++;
        chk_cnt++; if (glitches != 0) $display("FAIL burst_glitch: %0d mid-bit edges want 0", glitches); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int unsigned first;
        clear_mon();
        tx_bytes.delete();
        for (int i = 0; i < 6; i++) tx_bytes.push_back(8'($urandom));
        first = edge_cnt + 1;
        model_accepts(6, first);
        send_all(FRAME + 10);
        wait_idle(7 * FRAME, ok);
        chk_cnt++; if (!ok) $display("FAIL bp_drain: busy still high"); else pass_cnt++;
        foreach (exp_acc[i]) begin
            chk_cnt++; if (acc_e[i] != exp_acc[i]) $display("FAIL bp_accept[%0d]: edge %0d want %0d", i, acc_e[i], exp_acc[i]); else pass_cnt++;
        end
        chk_cnt++; if (rx_q.size() != 6) $display("FAIL bp_count: got %0d frames want 6", rx_q.size()); else pass_cnt++;
        foreach (tx_bytes[i]) begin
            chk_cnt++; if (rx_q[i] !== tx_bytes[i] || fall_q[i] != first + 2 + i * FRAME)
                $display("FAIL bp_order[%0d]: byte %h start %0d want %h %0d", i, rx_q[i], fall_q[i], tx_bytes[i], first + 2 + i * FRAME);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned first, target;
        clear_mon();
        tx_bytes = (CAP >= 2) ? '{8'h55, 8'($urandom), 8'($urandom)} : '{8'h55, 8'($urandom)};
        first = edge_cnt + 1;
        send_all(8);
        // Middle of data bit 3 of the first frame.
        target = first + 2 + 4 * C + C / 2;
        tick(int'(target - edge_cnt));
        chk_cnt++; if (tx !== 1'b0) $display("FAIL midrst_bit3: tx %b want 0 before reset", tx); else pass_cnt++;
        rst_n = 1'b0;
        tick(1);
        chk_cnt++; if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_now: tx %b busy %b want 1/0", tx, busy);
        else pass_cnt++;
        tick(2);
        rst_n = 1'b1;
        clear_mon();
        tick(3 * FRAME);
        chk_cnt++; if (rx_q.size() != 0 || in_frame)
            $display("FAIL midrst_stale: %0d frames in_frame %b want 0/0", rx_q.size(), in_frame);
        else pass_cnt++;
        chk_cnt++; if (tx !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1)
            $display("FAIL midrst_after: tx %b busy %b ready %b want 1/0/1", tx, busy, data_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_midframe();
        test_single();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
